// File: rtl/sram_link_pkg.sv
// Shared definitions for the byte-serial SRAM link: state encoding, field
// widths and the command-byte layout used by both ends of the link.
package sram_link_pkg;

  localparam int ADDR_W         = 5;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CMD_READ_BIT   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_RESP
  } state_t;

  // Command byte: [7:6] zero, [5] read flag, [4:0] word address.
  function automatic logic [7:0] build_cmd(input logic is_read,
                                           input logic [ADDR_W-1:0] addr);
    logic [7:0] cmd;
    cmd               = 8'h00;
    cmd[ADDR_W-1:0]   = addr;
    cmd[CMD_READ_BIT] = is_read;
    return cmd;
  endfunction

  // Write data goes out MSB first: index 0 selects bits [31:24].
  function automatic logic [7:0] wr_byte(input logic [DATA_W-1:0] data,
                                         input logic [1:0] idx);
    return data[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sram_link_initiator_if.sv
// Request/response, tx-byte and rx-byte channels of the SRAM link initiator.
// The master view belongs to the initiator, the slave view to its environment.
interface sram_link_initiator_if;

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [sram_link_pkg::ADDR_W-1:0] req_addr;
  logic [sram_link_pkg::DATA_W-1:0] req_wdata;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [sram_link_pkg::DATA_W-1:0] rsp_rdata;
  logic                             rsp_err;
  logic                             wr_done;

  logic [7:0]                       tx_data;
  logic                             tx_valid;
  logic                             tx_ready;

  logic [7:0]                       rx_data;
  logic                             rx_valid;
  logic                             rx_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           tx_ready, rx_data, rx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_done,
           tx_data, tx_valid, rx_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           tx_ready, rx_data, rx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_done,
           tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/sram_link_initiator.sv
// Host-side initiator: serializes read/write requests into command + data
// bytes and reassembles the four-byte read response, with an inter-byte
// timeout that aborts a stalled read.
module sram_link_initiator
  import sram_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_link_initiator_if.master bus
);

  localparam int              TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_t              r_state;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_idx;
  logic [TMR_W-1:0]    r_tmr;

  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_wr_done;

  logic                w_tx_fire;
  logic                w_rx_fire;
  logic [1:0]          w_idx_inc;

  assign w_tx_fire = r_tx_valid & bus.tx_ready;
  assign w_rx_fire = bus.rx_valid & bus.rx_ready;
  assign w_idx_inc = r_idx + 2'd1;

  // Ready signals decode straight from state; IDLE also swallows stray rx bytes.
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rx_ready  = (r_state == ST_IDLE) || (r_state == ST_RDATA);

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.wr_done   = r_wr_done;

  // Protocol FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_idx       <= 2'd0;
      r_tmr       <= '0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write    <= bus.req_write;
            r_wdata    <= bus.req_wdata;
            r_tx_data  <= build_cmd(!bus.req_write, bus.req_addr);
            r_tx_valid <= 1'b1;
            if (!bus.req_write) begin
              r_rsp_rdata <= '0;
            end
            r_state <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (w_tx_fire) begin
            r_idx <= 2'd0;
            if (r_write) begin
              r_tx_data <= wr_byte(r_wdata, 2'd0);
              r_state   <= ST_WDATA;
            end else begin
              r_tx_valid <= 1'b0;
              r_tmr      <= '0;
              r_state    <= ST_RDATA;
            end
          end
        end

        ST_WDATA: begin
          if (w_tx_fire) begin
            r_idx <= w_idx_inc;
            if (r_idx == LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_wr_done  <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_tx_data <= wr_byte(r_wdata, w_idx_inc);
            end
          end
        end

        ST_RDATA: begin
          // A byte arriving on the expiry cycle still counts as received.
          if (w_rx_fire) begin
            r_rsp_rdata[{r_idx, 3'b000} +: 8] <= bus.rx_data;
            r_idx <= w_idx_inc;
            r_tmr <= '0;
            if (r_idx == LAST_IDX) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_state     <= ST_RESP;
            end
          end else if (r_tmr == TMR_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
